// File: rtl/trng_entropy_reader.sv
// TRNG entropy reader: packs raw sampler bits into bytes, runs a repetition-count
// health test on the bit stream, and buffers bytes in a small FIFO behind a CPU
// register interface (DATA / STATUS / CTRL).
module trng_entropy_reader #(
  parameter int unsigned FIFO_DEPTH = 4,  // power of two, 2..8
  parameter int unsigned RCT_CUTOFF = 32  // 2..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  input  logic       data_read,
  output logic [7:0] data_out,
  output logic       data_ready
);

  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  Depth4  = 4'(FIFO_DEPTH);
  localparam logic [7:0]  Cutoff8 = 8'(RCT_CUTOFF);

  localparam logic [3:0] AddrData   = 4'h0;
  localparam logic [3:0] AddrStatus = 4'h1;
  localparam logic [3:0] AddrCtrl   = 4'h2;

  // Packer / health-test state
  logic            enable_q, enable_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      sreg_q, sreg_d;
  logic [7:0]      run_q, run_d;
  logic            last_q, last_d;
  logic            ovf_q, ovf_d;
  logic            fail_q, fail_d;
  // Completed byte waiting one cycle before entering the FIFO
  logic            push_q, push_d;
  logic [7:0]      push_data_q, push_data_d;

  // FIFO state
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [3:0]      count_q, count_d;

  logic       ctrl_wr, soft_clr, flush, drop_partial;
  logic       accept, byte_done, rct_trip;
  logic [7:0] byte_full, run_next;
  logic       full, pop, do_push, overflow, wr_en;

  // Decode CPU strobes, packer acceptance and FIFO events
  always_comb begin
    ctrl_wr      = data_write && (address == AddrCtrl);
    soft_clr     = ctrl_wr && data_in[1];
    flush        = ctrl_wr && data_in[2];
    drop_partial = ctrl_wr && (!data_in[0] || data_in[1]);

    accept    = bit_valid && enable_q && !fail_q;
    byte_full = {bit_in, sreg_q[7:1]};
    byte_done = accept && (bitcnt_q == 3'd7);

    if ((run_q == 8'd0) || (bit_in != last_q)) begin
      run_next = 8'd1;
    end else if (run_q < Cutoff8) begin
      run_next = run_q + 8'd1;
    end else begin
      run_next = run_q;
    end
    rct_trip = accept && (run_next == Cutoff8);

    full     = (count_q == Depth4);
    pop      = data_read && (address == AddrData) && (count_q != 4'd0);
    do_push  = push_q && !flush;
    // A pop in the same cycle frees the slot, so a full FIFO only overflows without one
    overflow = do_push && full && !pop;
    wr_en    = do_push && !overflow;
  end

  // Next-state for packer, health test, flags and FIFO bookkeeping
  always_comb begin
    enable_d    = ctrl_wr ? data_in[0] : enable_q;
    bitcnt_d    = bitcnt_q;
    sreg_d      = sreg_q;
    run_d       = run_q;
    last_d      = last_q;
    push_d      = byte_done && !rct_trip && !drop_partial;
    push_data_d = byte_full;
    fail_d      = fail_q || rct_trip;
    ovf_d       = ovf_q;

    if (accept) begin
      sreg_d   = byte_full;
      bitcnt_d = bitcnt_q + 3'd1;
      run_d    = run_next;
      last_d   = bit_in;
    end
    if (drop_partial) begin
      bitcnt_d = 3'd0;
      sreg_d   = 8'h00;
    end
    if (soft_clr) begin
      fail_d = 1'b0;
      ovf_d  = 1'b0;
      run_d  = 8'd0;
    end
    if (overflow) begin
      ovf_d = 1'b1;
    end

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = 4'd0;
    end else begin
      if (wr_en) wptr_d = wptr_q + PtrW'(1);
      if (pop)   rptr_d = rptr_q + PtrW'(1);
      count_d = count_q + {3'b000, wr_en} - {3'b000, pop};
    end
  end

  // Control and status registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q    <= 1'b0;
      bitcnt_q    <= 3'd0;
      sreg_q      <= 8'h00;
      run_q       <= 8'd0;
      last_q      <= 1'b0;
      ovf_q       <= 1'b0;
      fail_q      <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= 8'h00;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= 4'd0;
    end else begin
      enable_q    <= enable_d;
      bitcnt_q    <= bitcnt_d;
      sreg_q      <= sreg_d;
      run_q       <= run_d;
      last_q      <= last_d;
      ovf_q       <= ovf_d;
      fail_q      <= fail_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage; contents are only observed through count, so no reset needed
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem_q[wptr_q] <= push_data_q;
    end
  end

  // Register read mux; forced to zero while reset is held
  always_comb begin
    data_ready = !rst && (count_q != 4'd0);
    data_out   = 8'h00;
    if (!rst) begin
      case (address)
        AddrData:   data_out = (count_q != 4'd0) ? mem_q[rptr_q] : 8'h00;
        AddrStatus: data_out = {count_q, fail_q, ovf_q, full, count_q != 4'd0};
        AddrCtrl:   data_out = {7'b0000000, enable_q};
        default:    data_out = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_trng_entropy_reader.sv
// Self-checking bench for trng_entropy_reader: directed stimulus pushes the expected
// read response into a scoreboard; a monitor compares whenever a read is presented.
module tb_trng_entropy_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic [3:0] address = 4'h0;
  logic       data_write = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_read = 1'b0;
  logic [7:0] data_out;
  logic       data_ready;

  trng_entropy_reader #(
    .FIFO_DEPTH(4),
    .RCT_CUTOFF(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .address   (address),
    .data_write(data_write),
    .data_in   (data_in),
    .data_read (data_read),
    .data_out  (data_out),
    .data_ready(data_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       rdy;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: every presented read is compared against the oldest expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (data_read) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected addr=%0h: got data=%02h ready=%0b, no expectation queued",
                 address, data_out, data_ready);
      end else begin
        e = sb_q.pop_front();
        if (data_out !== e.data || data_ready !== e.rdy) begin
          errors++;
          $display("FAIL read addr=%0h @%0t: got data=%02h ready=%0b, expected data=%02h ready=%0b",
                   address, $time, data_out, data_ready, e.data, e.rdy);
        end
      end
    end
  end

  // One clock of stimulus; inputs change 1ns after the rising edge
  task automatic step(input logic bv, input logic b, input logic rd, input logic wr,
                      input logic [3:0] a, input logic [7:0] wd,
                      input logic [7:0] exp_d, input logic exp_r);
    bit_valid  = bv;
    bit_in     = b;
    data_read  = rd;
    data_write = wr;
    address    = a;
    data_in    = wd;
    if (rd) sb_q.push_back('{data: exp_d, rdy: exp_r});
    @(posedge clk);
    #1;
    bit_valid  = 1'b0;
    bit_in     = 1'b0;
    data_read  = 1'b0;
    data_write = 1'b0;
    address    = 4'h0;
    data_in    = 8'h00;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp_d, input logic exp_r);
    step(1'b0, 1'b0, 1'b1, 1'b0, a, 8'h00, exp_d, exp_r);
  endtask

  task automatic rd_st(input logic [7:0] exp_d);
    logic [7:0] s;
    s = exp_d;
    rd(4'h1, s, s[0]);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    step(1'b0, 1'b0, 1'b0, 1'b1, a, d, 8'h00, 1'b0);
  endtask

  task automatic feed_bit(input logic b);
    step(1'b1, b, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic feed_byte(input logic [7:0] d);
    for (int i = 0; i < 8; i++) feed_bit(d[i]);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] v;
    // Reset: outputs forced to zero at every address while rst is held
    @(posedge clk);
    #1;
    rd(4'h0, 8'h00, 1'b0);
    rd(4'h1, 8'h00, 1'b0);
    rd(4'h2, 8'h00, 1'b0);
    rd(4'h7, 8'h00, 1'b0);
    rst = 1'b0;
    rd_st(8'h00);
    rd(4'h2, 8'h00, 1'b0);

    // Basic byte 0x4D, one-cycle push latency
    wr(4'h2, 8'h01);
    rd(4'h2, 8'h01, 1'b0);
    wr(4'h5, 8'hFF);                    // ignored address
    rd(4'h5, 8'h00, 1'b0);
    feed_bit(1'b1); feed_bit(1'b0); feed_bit(1'b1); feed_bit(1'b1);
    feed_bit(1'b0); feed_bit(1'b0); feed_bit(1'b1); feed_bit(1'b0);
    rd_st(8'h00);                       // byte not yet visible
    rd_st(8'h11);
    rd(4'h0, 8'h4D, 1'b1);
    rd_st(8'h00);

    // Five bytes, no reads: overflow drops the fifth
    feed_byte(8'h11); feed_byte(8'h22); feed_byte(8'h33);
    feed_byte(8'h44); feed_byte(8'h55);
    idle();
    rd_st(8'h47);
    rd(4'h0, 8'h11, 1'b1);
    rd(4'h0, 8'h22, 1'b1);
    rd(4'h0, 8'h33, 1'b1);
    rd(4'h0, 8'h44, 1'b1);
    rd_st(8'h04);
    rd(4'h0, 8'h00, 1'b0);              // empty read: no pop, no flag change
    rd_st(8'h04);
    wr(4'h2, 8'h03);
    rd_st(8'h00);

    // Full FIFO: pop on the 8th-bit cycle, then pop on the push cycle
    feed_byte(8'hA1); feed_byte(8'hB2); feed_byte(8'hC3); feed_byte(8'hD4);
    idle();
    rd_st(8'h43);
    v = 8'hE5;
    for (int i = 0; i < 7; i++) feed_bit(v[i]);
    step(1'b1, v[7], 1'b1, 1'b0, 4'h0, 8'h00, 8'hA1, 1'b1);
    idle();
    rd_st(8'h43);
    feed_byte(8'h5A);
    rd(4'h0, 8'hB2, 1'b1);              // same edge as the push of 0x5A
    rd_st(8'h43);
    rd(4'h0, 8'hC3, 1'b1);
    rd(4'h0, 8'hD4, 1'b1);
    rd(4'h0, 8'hE5, 1'b1);
    rd(4'h0, 8'h5A, 1'b1);
    rd_st(8'h00);

    // Repetition-count test at the cutoff of 32
    wr(4'h2, 8'h07);
    for (int i = 0; i < 31; i++) feed_bit(1'b1);
    idle();
    rd_st(8'h31);
    feed_bit(1'b1);
    idle();
    rd_st(8'h39);
    feed_byte(8'h00);                   // frozen: ignored
    idle();
    rd_st(8'h39);
    wr(4'h2, 8'h03);
    rd_st(8'h31);
    rd(4'h0, 8'hFF, 1'b1);
    rd(4'h0, 8'hFF, 1'b1);
    rd(4'h0, 8'hFF, 1'b1);
    feed_byte(8'h96);
    idle();
    rd(4'h0, 8'h96, 1'b1);
    rd_st(8'h00);

    // Flush in the push cycle wins
    feed_byte(8'h12);
    idle();
    feed_byte(8'h34);
    wr(4'h2, 8'h05);
    idle();
    rd_st(8'h00);
    rd(4'h0, 8'h00, 1'b0);

    // Disable discards the partial byte
    feed_bit(1'b1); feed_bit(1'b1); feed_bit(1'b1);
    wr(4'h2, 8'h00);
    rd(4'h2, 8'h00, 1'b0);
    wr(4'h2, 8'h01);
    feed_byte(8'h3C);
    idle();
    rd_st(8'h11);
    rd(4'h0, 8'h3C, 1'b1);

    // Reset mid-byte with a byte in the FIFO
    feed_byte(8'h77);
    idle();
    feed_bit(1'b1); feed_bit(1'b0); feed_bit(1'b1); feed_bit(1'b0); feed_bit(1'b1);
    rst = 1'b1;
    rd(4'h1, 8'h00, 1'b0);
    rd(4'h0, 8'h00, 1'b0);
    rst = 1'b0;
    rd(4'h2, 8'h00, 1'b0);
    rd_st(8'h00);
    wr(4'h2, 8'h01);
    feed_byte(8'h00);
    idle();
    rd_st(8'h11);
    rd(4'h0, 8'h00, 1'b1);
    rd_st(8'h00);

    idle();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trng_entropy_reader.md
TRNG_ENTROPY_READER -- requirements
Module: trng_entropy_reader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, giving the byte FIFO depth; only powers of two from 2 to 8 are legal.
REQ-002 SHALL have parameter RCT_CUTOFF, default 32, giving the repetition-count health-test cutoff in bits; legal range is 2 to 255.
REQ-003 SHALL use one clock and a synchronous, active-high reset, with ports as follows.
- clk, input, 1 bit: sole clock, all state updates on the rising edge.
- rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have the remaining ports below.
- bit_in, input, 1 bit: raw entropy bit from the ring-oscillator XOR sampler.
- bit_valid, input, 1 bit: bit_in is valid this cycle.
- address, input, 4 bits: register select.
- data_write, input, 1 bit: CPU write strobe.
- data_in, input, 8 bits: write data.
- data_read, input, 1 bit: CPU read strobe, single cycle.
- data_out, output, 8 bits: read data, combinational from address and state.
- data_ready, output, 1 bit: FIFO not empty, usable as an interrupt.

Function
REQ-005 The packer SHALL shift in bit_in only on a cycle where bit_valid=1, enable=1 and fail=0.
REQ-006 On each accepted bit the packer SHALL load the bit into sreg[7] and shift sreg right, so the first bit accepted ends up in bit 0.
REQ-007 A 3-bit bit counter SHALL count accepted bits; on the 8th accepted bit the completed byte (sreg plus the new bit) SHALL be pushed and the counter SHALL wrap to 0.
REQ-008 Push latency SHALL be 1 cycle: the 8th bit accepted at edge N makes the byte visible, with data_ready=1, after edge N+1.
REQ-009 A push while the FIFO is full SHALL drop the byte and set the sticky ovf flag; FIFO contents SHALL be unchanged.
REQ-010 The repetition-count test SHALL track the run length of identical accepted bits, starting at 1 on a new value and saturating at RCT_CUTOFF.
REQ-011 When the run length reaches RCT_CUTOFF, sticky fail SHALL set, and a byte completing on that same bit SHALL be discarded.
REQ-012 While fail=1, the packer and the run counter SHALL freeze.
REQ-013 Address 0x0 (DATA) SHALL read the FIFO head.
REQ-014 A data_read at 0x0 with the FIFO non-empty SHALL pop one entry; with the FIFO empty it SHALL return 0x00, with no pop and no flag change.
REQ-015 Address 0x1 (STATUS) SHALL read [0] data_ready, [1] full, [2] ovf, [3] fail, [7:4] occupancy count.
REQ-016 Address 0x2 (CTRL) SHALL read {7'b0, enable}.
REQ-017 A write to 0x2 SHALL set enable=data_in[0].
- data_in[1]=1 SHALL self-clear the ovf and fail flags, reset the run counter and discard any partial byte.
- data_in[2]=1 SHALL flush the FIFO.
REQ-018 Other addresses SHALL read 0x00, writes to them SHALL be ignored, and a data_read to any address other than 0x0 SHALL have no side effects.
REQ-019 A simultaneous push and pop SHALL both occur and leave the count unchanged; on a full FIFO the pop frees the slot, so no overflow occurs.
REQ-020 A flush in the same cycle as a push SHALL win: the FIFO ends empty and the byte is lost.
REQ-021 A write of enable=0 SHALL discard the partial byte (bit counter to 0) but SHALL keep FIFO contents and flags.
REQ-022 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be held separately, so full and empty are unambiguous.

Reset
REQ-023 While rst=1 at a clock edge, the block SHALL set enable=0, bit counter=0, sreg=0x00, run counter=0, FIFO empty with both pointers 0, and ovf=0, fail=0.
REQ-024 During reset, data_ready SHALL be 0, and data_out SHALL be 0x00 at every address.
REQ-025 A reset asserted mid-byte or mid-run SHALL discard all partial state, and the first accepted bit after reset SHALL become bit 0 of a new byte.

Verification
REQ-026 Enable, then feed bits 1,0,1,1,0,0,1,0 -> one cycle after the 8th bit, data_ready=1 and STATUS=0x11; a DATA read returns 0x4D, then STATUS=0x00.
REQ-027 Feed 5 bytes with no reads -> STATUS=0x47 (count 4, full, ovf, ready), and the four reads return the first four bytes in order.
REQ-028 Feed 31 ones -> fail=0; the 32nd one -> fail=1, exactly 3 bytes of 0xFF in the FIFO, and further bits are ignored; write CTRL=0x03 -> fail=0 and packing resumes.
REQ-029 With FIFO full, issue a DATA read in the same cycle the 8th bit of a new byte is accepted -> on the push cycle the count stays 4, ovf=0, and the new byte is last in order.
REQ-030 Assert rst after 5 accepted bits -> all state is cleared; then feed 8 bits of 0x00 -> exactly one byte 0x00 is pushed.
